rv_bus_arbiter: RTL and testbench
=================================

# rv_bus_arbiter

Shares the single external memory bus (Wishbone-classic style, single-beat) between the instruction-fetch port and the load/store unit. It sits between the core and the memory interconnect. It grants one requester at a time and holds the bus until the slave acknowledges. Data requests have priority, but a bounded starvation guard protects fetch. A watchdog terminates hung transactions with an error.

## Interface
- `DATA_PRIORITY`, default 1: 1 gives the data port priority when both ports request in the same cycle; 0 gives fetch priority.
- `STARVE_LIMIT`, default 4: the number of consecutive grants the priority port may win while the other port waits. After that, the waiting port wins once. Range 1–15.
- `TIMEOUT_CYCLES`, default 255: the number of cycles without `i_wb_ack` before the transaction is aborted with an error. 0 disables the watchdog. Range 0–65535.
- `i_clk`, input, 1: the core clock.
- `i_reset_n`, input, 1: asynchronous, active-low reset.
- `i_if_cyc`, input, 1: fetch request (driven from fetch `o_cyc`).
- `i_if_addr`, input, 32: fetch address, word aligned.
- `o_if_ack`, output, 1: fetch acknowledge, 1-cycle pulse.
- `o_if_data`, output, 32: fetch read data. Valid only while `o_if_ack` is high.
- `o_if_err`, output, 1: fetch bus error or timeout, 1-cycle pulse.
- `i_d_cyc`, input, 1: data request.
- `i_d_we`, input, 1: data write enable.
- `i_d_sel`, input, 4: data byte lanes.
- `i_d_addr`, input, 32: data address.
- `i_d_wdata`, input, 32: data write data.
- `o_d_ack`, output, 1: data acknowledge.
- `o_d_rdata`, output, 32: data read data.
- `o_d_err`, output, 1: data bus error or timeout.
- `o_wb_cyc`, `o_wb_stb`, output, 1 each: bus cycle and strobe. The two are always equal.
- `o_wb_we`, output, 1: bus write enable.
- `o_wb_sel`, output, 4: bus byte lanes.
- `o_wb_adr`, output, 32: bus address.
- `o_wb_dat`, output, 32: bus write data.
- `i_wb_ack`, input, 1: bus acknowledge.
- `i_wb_err`, input, 1: bus error.
- `i_wb_dat`, input, 32: bus read data.

## Operation
- The FSM has three states: IDLE, GNT_IF and GNT_D. Reset puts it in IDLE.
- **IDLE.** If a request is pending, the arbitration winner is latched: address, we, sel and wdata are registered, and the state moves to GNT_x. The fetch port latches `we=0` and `sel=4'hF`.
- **Arbitration.** The priority port wins unless the starvation counter has reached `STARVE_LIMIT` while the other port is requesting. In that case the other port wins and the counter clears.
  - The counter increments on each priority-port grant made while the other port is requesting.
  - It clears on any grant made while the other port is idle.
- **GNT_x.** `o_wb_cyc` and `o_wb_stb` are driven high, and all bus outputs come from the latched registers. The transaction ends when any of these occurs:
  - `i_wb_ack` is high: forward ack and data to the owner.
  - `i_wb_err` is high: forward err to the owner.
  - The watchdog reaches `TIMEOUT_CYCLES`: forward err to the owner.
- **On completion**, arbitration runs again in the same cycle. If a request is pending, the FSM goes straight to the next GNT state with the new latch, so there is no idle bubble. Otherwise it returns to IDLE.
- **Abandoned fetch.** If `i_if_cyc` drops while in GNT_IF (a redirect), the bus cycle is not aborted. The arbiter waits for the ack, and the ack/err pulse to fetch is suppressed. The arbiter records this in an `if_abandon` flag, which clears on completion.
- **Data request.** The LSU keeps `i_d_cyc` asserted until ack. A drop of `i_d_cyc` mid-transaction is a protocol violation and is not handled.
- **Ack and error together.** If `i_wb_ack` and `i_wb_err` are high in the same cycle, the error wins: err is forwarded and ack is not.

## Timing
- **Reset values.** All outputs are 0 while `i_reset_n` is low; this covers the `o_wb_*` buses, the acks, the errs and the read data. Internal reset values: FSM in IDLE, starvation counter 0, watchdog 0, `if_abandon` 0.
- **Request to bus.** A request sampled in IDLE drives `o_wb_cyc` on the next cycle, giving 1-cycle latency.
- **Ack path.** The requester ack is combinational from `i_wb_ack` in the same cycle. The read data muxes are combinational.
- **Back-to-back throughput.** One transaction per slave-ack cycle.
- **Watchdog.**
  - It clears on each new grant.
  - It increments each GNT cycle without ack or err.
  - An error fires in the cycle where it equals `TIMEOUT_CYCLES`, and `o_wb_cyc` drops on the next cycle.
- **Simultaneous requests in IDLE** are resolved by the arbitration rule.
- **Asynchronous reset mid-transaction** drops `o_wb_cyc` immediately and no ack is produced.

## Structure
- Shared package `rv_bus_pkg`:
  - `typedef enum logic[1:0] {ARB_IDLE, ARB_GNT_IF, ARB_GNT_D}`;
  - a `wb_req_t` struct with fields adr, dat, sel and we;
  - the `WB_SEL_ALL` constant.
- Sub-module `rv_bus_watchdog`: a counter with clear/enable inputs and a `timeout` output. Its width is `$clog2(TIMEOUT_CYCLES+1)`.
- The FSM, the arbitration logic and the request latch live in the top module.

## Test plan
- **Single fetch.** Drive `i_if_cyc=1` with addr `0x100`; the slave acks 2 cycles after `cyc`. Required: `o_wb_adr=0x100`, `we=0`, `sel=F`; `o_if_ack` pulses with `o_if_data=i_wb_dat`; the FSM returns to IDLE.
- **Priority and starvation.** Hold both requests with ack every cycle, `DATA_PRIORITY=1`, `STARVE_LIMIT=4`. Required grant sequence: D, D, D, D, IF, D, D, D, D, IF, with no idle bubbles.
- **Abandoned fetch.** Drop `i_if_cyc` one cycle into GNT_IF; the slave acks 3 cycles later. Required: no `o_if_ack`; `o_wb_cyc` is held until the ack; a pending data request is granted in the ack cycle.
- **Write.** Drive `i_d_we=1`, `sel=4'b0011`, wdata `0xDEADBEEF`, addr `0x2004`. Required: the bus outputs match the latched values, and they stay stable even if the LSU changes its inputs mid-cycle.
- **Timeout.** Set `TIMEOUT_CYCLES=8` and never ack. Required: `o_d_err` pulses at grant+8, `o_wb_cyc` drops the next cycle, and the next request is serviced normally. Also drive `i_wb_err` and `i_wb_ack` high in the same cycle: `o_d_err` pulses and `o_d_ack` stays low.
- **Reset mid-transaction.** Assert `i_reset_n=0` during GNT_D. Required: all outputs go to 0 asynchronously, and after release the FSM is in IDLE with the counters at 0.

Source files
------------

// File: rtl/rv_bus_pkg.sv
// Shared types and constants for the instruction/data bus arbiter.
package rv_bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GNT_IF = 2'd1,
        ARB_GNT_D  = 2'd2
    } arb_state_t;

    // One latched single-beat bus request.
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } wb_req_t;

    localparam logic [3:0] WB_SEL_ALL = 4'hF;

    // Fetch is always a full-word read.
    function automatic wb_req_t fetch_req(input logic [31:0] adr);
        wb_req_t r;
        r.adr = adr;
        r.dat = 32'h0;
        r.sel = WB_SEL_ALL;
        r.we  = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/rv_bus_watchdog.sv
// Cycle counter that flags a bus transaction left without response for
// TIMEOUT_CYCLES cycles. TIMEOUT_CYCLES = 0 disables it.
module rv_bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

    logic [W-1:0] cnt;

    // Count waiting cycles; stop at the limit so the value never wraps.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == LIMIT);

endmodule

// File: rtl/rv_bus_arbiter.sv
// Two-port (fetch / load-store) arbiter onto one single-beat Wishbone bus.
//
// Handshake: a requester raises *_cyc with its request fields and holds them
// until it sees its ack or err pulse. The arbiter owns the bus from grant
// until the slave acks or errs (or the watchdog fires); ack/err are passed
// back combinationally in that same cycle, and the next owner is chosen in
// that same cycle so back-to-back transfers have no idle bubble.
module rv_bus_arbiter
    import rv_bus_pkg::*;
#(
    parameter int DATA_PRIORITY  = 1,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_if_cyc,
    input  logic [31:0] i_if_addr,
    output logic        o_if_ack,
    output logic [31:0] o_if_data,
    output logic        o_if_err,
    input  logic        i_d_cyc,
    input  logic        i_d_we,
    input  logic [3:0]  i_d_sel,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    output logic        o_d_ack,
    output logic [31:0] o_d_rdata,
    output logic        o_d_err,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_sel,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_dat,
    output logic [1:0]  o_dbg_state
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    arb_state_t state;
    wb_req_t    req_q;
    logic [3:0] starve_cnt;
    logic       if_abandon;

    logic       busy;
    logic       wd_timeout;
    logic       err_hit;
    logic       ack_hit;
    logic       done;
    logic       arb_en;
    logic       any_req;
    logic       prio_req;
    logic       other_req;
    logic       pick_other;
    logic       grant_d;
    logic [3:0] starve_next;
    wb_req_t    next_req;

    assign busy    = (state != ARB_IDLE);
    assign err_hit = i_wb_err || wd_timeout;
    assign ack_hit = i_wb_ack && !err_hit;
    assign done    = busy && (i_wb_ack || err_hit);
    assign arb_en  = !busy || done;
    assign any_req = i_if_cyc || i_d_cyc;

    rv_bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .clr      (!busy || done),
        .en       (busy && !i_wb_ack && !i_wb_err),
        .timeout  (wd_timeout)
    );

    // Pick the next owner: priority port unless the waiting port is starved.
    always_comb begin
        prio_req    = (DATA_PRIORITY != 0) ? i_d_cyc : i_if_cyc;
        other_req   = (DATA_PRIORITY != 0) ? i_if_cyc : i_d_cyc;
        pick_other  = other_req && (!prio_req || (starve_cnt >= STARVE_LIM));
        grant_d     = (DATA_PRIORITY != 0) ? !pick_other : pick_other;
        starve_next = (prio_req && other_req && !pick_other) ? starve_cnt + 4'd1 : 4'd0;
        if (grant_d) begin
            next_req = '{adr: i_d_addr, dat: i_d_wdata, sel: i_d_sel, we: i_d_we};
        end else begin
            next_req = fetch_req(i_if_addr);
        end
    end

    // Grant FSM with request latch, starvation counter and abandon flag.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= ARB_IDLE;
            req_q      <= '0;
            starve_cnt <= 4'd0;
            if_abandon <= 1'b0;
        end else begin
            if (done) begin
                if_abandon <= 1'b0;
            end else if ((state == ARB_GNT_IF) && !i_if_cyc) begin
                if_abandon <= 1'b1;
            end
            if (arb_en) begin
                if (any_req) begin
                    state      <= grant_d ? ARB_GNT_D : ARB_GNT_IF;
                    req_q      <= next_req;
                    starve_cnt <= starve_next;
                end else begin
                    state <= ARB_IDLE;
                end
            end
        end
    end

    // Bus side is driven only while a grant is held.
    assign o_wb_cyc = busy;
    assign o_wb_stb = busy;
    assign o_wb_we  = busy && req_q.we;
    assign o_wb_sel = busy ? req_q.sel : 4'h0;
    assign o_wb_adr = busy ? req_q.adr : 32'h0;
    assign o_wb_dat = busy ? req_q.dat : 32'h0;

    // Route completion to the owner; an abandoned fetch gets nothing.
    assign o_if_ack  = (state == ARB_GNT_IF) && ack_hit && !if_abandon;
    assign o_if_err  = (state == ARB_GNT_IF) && err_hit && !if_abandon;
    assign o_if_data = o_if_ack ? i_wb_dat : 32'h0;
    assign o_d_ack   = (state == ARB_GNT_D) && ack_hit;
    assign o_d_err   = (state == ARB_GNT_D) && err_hit;
    assign o_d_rdata = o_d_ack ? i_wb_dat : 32'h0;

    assign o_dbg_state = state;

endmodule

// File: tb/tb_rv_bus_arbiter.sv
// Directed bench for rv_bus_arbiter: fetch, priority/starvation, abandoned
// fetch, writes, watchdog, ack+err collision and reset mid-transaction.
module tb_rv_bus_arbiter;
    import rv_bus_pkg::*;

    localparam int TMO = 8;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_if_cyc;
    logic [31:0] i_if_addr;
    logic        o_if_ack;
    logic [31:0] o_if_data;
    logic        o_if_err;
    logic        i_d_cyc;
    logic        i_d_we;
    logic [3:0]  i_d_sel;
    logic [31:0] i_d_addr;
    logic [31:0] i_d_wdata;
    logic        o_d_ack;
    logic [31:0] o_d_rdata;
    logic        o_d_err;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic        i_wb_ack;
    logic        i_wb_err;
    logic [31:0] i_wb_dat;
    logic [1:0]  o_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    rv_bus_arbiter #(
        .DATA_PRIORITY (1),
        .STARVE_LIMIT  (4),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_if_cyc   (i_if_cyc),
        .i_if_addr  (i_if_addr),
        .o_if_ack   (o_if_ack),
        .o_if_data  (o_if_data),
        .o_if_err   (o_if_err),
        .i_d_cyc    (i_d_cyc),
        .i_d_we     (i_d_we),
        .i_d_sel    (i_d_sel),
        .i_d_addr   (i_d_addr),
        .i_d_wdata  (i_d_wdata),
        .o_d_ack    (o_d_ack),
        .o_d_rdata  (o_d_rdata),
        .o_d_err    (o_d_err),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_we    (o_wb_we),
        .o_wb_sel   (o_wb_sel),
        .o_wb_adr   (o_wb_adr),
        .o_wb_dat   (o_wb_dat),
        .i_wb_ack   (i_wb_ack),
        .i_wb_err   (i_wb_err),
        .i_wb_dat   (i_wb_dat),
        .o_dbg_state(o_dbg_state)
    );

    // Slave memory contents as a function of address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'hA5A5_0F0F ^ {a[15:0], a[31:16]};
    endfunction

    function automatic logic [138:0] all_outs();
        return {o_if_ack, o_if_data, o_if_err, o_d_ack, o_d_rdata, o_d_err,
                o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_adr, o_wb_dat};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        i_if_cyc  = 1'b0;
        i_if_addr = 32'h0;
        i_d_cyc   = 1'b0;
        i_d_we    = 1'b0;
        i_d_sel   = 4'h0;
        i_d_addr  = 32'h0;
        i_d_wdata = 32'h0;
        i_wb_ack  = 1'b0;
        i_wb_err  = 1'b0;
        i_wb_dat  = 32'h0;
    endtask

    task automatic slave_respond(input logic ack, input logic err);
        i_wb_ack = ack;
        i_wb_err = err;
        i_wb_dat = ack ? mem_fn(o_wb_adr) : 32'($urandom_range(0, 32'hFFFF));
    endtask

    task automatic d_read(input logic [31:0] a);
        i_d_cyc   = 1'b1;
        i_d_we    = 1'b0;
        i_d_sel   = 4'hF;
        i_d_addr  = a;
        i_d_wdata = 32'h0;
    endtask

    // Called on a negedge; returns on the negedge where o_wb_cyc is seen.
    task automatic wait_bus(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (o_wb_cyc) begin
                ok = 1'b1;
                break;
            end
            @(negedge i_clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        i_reset_n = 1'b0;
        i_if_cyc  = 1'b1;
        i_wb_ack  = 1'b1;
        i_wb_dat  = 32'hFFFF_FFFF;
        @(negedge i_clk);
        #1;
        n_checks++;
        if (all_outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", all_outs());
        end
        idle_inputs();
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(negedge i_clk);
        #1;
        n_checks++;
        if ({o_dbg_state, o_wb_cyc} !== {ARB_IDLE, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_idle: got state %0d cyc %b required 0 0", o_dbg_state, o_wb_cyc);
        end
    endtask

    task automatic test_single_fetch();
        logic [31:0] e;
        @(negedge i_clk);
        i_if_cyc  = 1'b1;
        i_if_addr = 32'h100;
        exp_q.push_back(mem_fn(32'h100));
        @(negedge i_clk);
        #1;
        n_checks++;
        if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_adr, o_if_ack} !== {1'b1, 1'b1, 1'b0, 4'hF, 32'h100, 1'b0}) begin
            n_fail++;
            $display("FAIL fetch_bus: got cyc%b stb%b we%b sel%h adr%h ack%b required 1 1 0 f 00000100 0",
                     o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_adr, o_if_ack);
        end
        @(negedge i_clk);
        #1;
        n_checks++;
        if ({o_wb_cyc, o_if_ack} !== 2'b10) begin
            n_fail++;
            $display("FAIL fetch_wait: got cyc%b ack%b required 1 0", o_wb_cyc, o_if_ack);
        end
        @(negedge i_clk);
        slave_respond(1'b1, 1'b0);
        i_if_cyc = 1'b0;
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if ({o_if_ack, o_if_data, o_d_ack} !== {1'b1, e, 1'b0}) begin
            n_fail++;
            $display("FAIL fetch_ack: got ack%b data %h d_ack%b required 1 %h 0", o_if_ack, o_if_data, o_d_ack, e);
        end
        @(negedge i_clk);
        slave_respond(1'b0, 1'b0);
        #1;
        n_checks++;
        if ({o_dbg_state, o_wb_cyc} !== {ARB_IDLE, 1'b0}) begin
            n_fail++;
            $display("FAIL fetch_idle: got state %0d cyc %b required 0 0", o_dbg_state, o_wb_cyc);
        end
    endtask

    task automatic test_starvation();
        bit ok;
        logic [31:0] ea;
        logic is_d;
        logic [31:0] got_data;
        @(negedge i_clk);
        i_if_cyc  = 1'b1;
        i_if_addr = 32'h1000;
        d_read(32'h2000);
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(((i % 5) == 4) ? 32'h1000 : 32'h2000);
        end
        @(negedge i_clk);
        wait_bus(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL starve_grant_wait: no o_wb_cyc within 20 cycles, required a grant");
        end
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge i_clk);
            slave_respond(1'b1, 1'b0);
            if (i == 9) begin
                i_if_cyc = 1'b0;
                i_d_cyc  = 1'b0;
            end
            #1;
            ea   = exp_q.pop_front();
            is_d = (ea == 32'h2000);
            got_data = is_d ? o_d_rdata : o_if_data;
            n_checks++;
            if ({o_wb_cyc, o_wb_adr, o_d_ack, o_if_ack, got_data} !== {1'b1, ea, is_d, ~is_d, mem_fn(ea)}) begin
                n_fail++;
                $display("FAIL starve_grant_%0d: got cyc%b adr %h d_ack%b if_ack%b data %h required 1 %h %b %b %h",
                         i, o_wb_cyc, o_wb_adr, o_d_ack, o_if_ack, got_data, ea, is_d, ~is_d, mem_fn(ea));
            end
        end
        @(negedge i_clk);
        slave_respond(1'b0, 1'b0);
        #1;
        n_checks++;
        if ({o_dbg_state, o_wb_cyc} !== {ARB_IDLE, 1'b0}) begin
            n_fail++;
            $display("FAIL starve_idle: got state %0d cyc %b required 0 0", o_dbg_state, o_wb_cyc);
        end
    endtask

    task automatic test_abandon();
        logic [31:0] e;
        @(negedge i_clk);
        i_if_cyc  = 1'b1;
        i_if_addr = 32'h200;
        @(negedge i_clk);
        #1;
        n_checks++;
        if ({o_dbg_state, o_wb_adr} !== {ARB_GNT_IF, 32'h200}) begin
            n_fail++;
            $display("FAIL abandon_grant: got state %0d adr %h required 1 00000200", o_dbg_state, o_wb_adr);
        end
        i_if_cyc = 1'b0;
        d_read(32'h300);
        exp_q.push_back(mem_fn(32'h300));
        for (int i = 0; i < 2; i++) begin
            @(negedge i_clk);
            #1;
            n_checks++;
            if ({o_wb_cyc, o_wb_adr, o_if_ack} !== {1'b1, 32'h200, 1'b0}) begin
                n_fail++;
                $display("FAIL abandon_hold_%0d: got cyc%b adr %h ack%b required 1 00000200 0", i, o_wb_cyc, o_wb_adr, o_if_ack);
            end
        end
        @(negedge i_clk);
        slave_respond(1'b1, 1'b0);
        #1;
        n_checks++;
        if ({o_if_ack, o_if_err, o_d_ack} !== 3'b000) begin
            n_fail++;
            $display("FAIL abandon_ack_suppressed: got if_ack%b if_err%b d_ack%b required 0 0 0", o_if_ack, o_if_err, o_d_ack);
        end
        @(negedge i_clk);
        slave_respond(1'b1, 1'b0);
        i_d_cyc = 1'b0;
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if ({o_dbg_state, o_wb_adr, o_d_ack, o_d_rdata} !== {ARB_GNT_D, 32'h300, 1'b1, e}) begin
            n_fail++;
            $display("FAIL abandon_next_d: got state %0d adr %h ack%b data %h required 2 00000300 1 %h",
                     o_dbg_state, o_wb_adr, o_d_ack, o_d_rdata, e);
        end
        @(negedge i_clk);
        slave_respond(1'b0, 1'b0);
        #1;
        n_checks++;
        if (o_dbg_state !== ARB_IDLE) begin
            n_fail++;
            $display("FAIL abandon_idle: got state %0d required 0", o_dbg_state);
        end
    endtask

    task automatic test_write();
        @(negedge i_clk);
        i_d_cyc   = 1'b1;
        i_d_we    = 1'b1;
        i_d_sel   = 4'b0011;
        i_d_wdata = 32'hDEAD_BEEF;
        i_d_addr  = 32'h2004;
        for (int i = 0; i < 2; i++) begin
            @(negedge i_clk);
            #1;
            n_checks++;
            if ({o_wb_cyc, o_wb_we, o_wb_sel, o_wb_adr, o_wb_dat} !== {1'b1, 1'b1, 4'b0011, 32'h2004, 32'hDEAD_BEEF}) begin
                n_fail++;
                $display("FAIL write_bus_%0d: got cyc%b we%b sel%h adr %h dat %h required 1 1 3 00002004 deadbeef",
                         i, o_wb_cyc, o_wb_we, o_wb_sel, o_wb_adr, o_wb_dat);
            end
            i_d_we    = 1'b0;
            i_d_sel   = 4'hC;
            i_d_wdata = 32'($urandom);
            i_d_addr  = 32'hFFFF_0000;
        end
        @(negedge i_clk);
        slave_respond(1'b1, 1'b0);
        i_d_cyc = 1'b0;
        #1;
        n_checks++;
        if ({o_d_ack, o_d_err, o_if_ack} !== 3'b100) begin
            n_fail++;
            $display("FAIL write_ack: got ack%b err%b if_ack%b required 1 0 0", o_d_ack, o_d_err, o_if_ack);
        end
        @(negedge i_clk);
        slave_respond(1'b0, 1'b0);
        idle_inputs();
    endtask

    task automatic test_timeout();
        bit ok;
        logic [31:0] e;
        @(negedge i_clk);
        d_read(32'h400);
        for (int k = 1; k <= TMO; k++) begin
            @(negedge i_clk);
            #1;
            n_checks++;
            if ({o_wb_cyc, o_d_err, o_d_ack} !== 3'b100) begin
                n_fail++;
                $display("FAIL timeout_wait_%0d: got cyc%b err%b ack%b required 1 0 0", k, o_wb_cyc, o_d_err, o_d_ack);
            end
        end
        @(negedge i_clk);
        i_d_cyc = 1'b0;
        #1;
        n_checks++;
        if ({o_wb_cyc, o_d_err, o_d_ack} !== 3'b110) begin
            n_fail++;
            $display("FAIL timeout_err: got cyc%b err%b ack%b required 1 1 0", o_wb_cyc, o_d_err, o_d_ack);
        end
        @(negedge i_clk);
        #1;
        n_checks++;
        if ({o_wb_cyc, o_d_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_drop: got cyc%b err%b required 0 0", o_wb_cyc, o_d_err);
        end
        d_read(32'h404);
        exp_q.push_back(mem_fn(32'h404));
        @(negedge i_clk);
        wait_bus(ok);
        slave_respond(1'b1, 1'b0);
        i_d_cyc = 1'b0;
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if ({ok, o_d_ack, o_d_err, o_d_rdata} !== {1'b1, 1'b1, 1'b0, e}) begin
            n_fail++;
            $display("FAIL timeout_recover: got granted%b ack%b err%b data %h required 1 1 0 %h", ok, o_d_ack, o_d_err, o_d_rdata, e);
        end
        @(negedge i_clk);
        slave_respond(1'b0, 1'b0);
    endtask

    task automatic test_err_ack();
        @(negedge i_clk);
        d_read(32'h500);
        @(negedge i_clk);
        slave_respond(1'b1, 1'b1);
        i_d_cyc = 1'b0;
        #1;
        n_checks++;
        if ({o_d_err, o_d_ack} !== 2'b10) begin
            n_fail++;
            $display("FAIL err_wins_d: got err%b ack%b required 1 0", o_d_err, o_d_ack);
        end
        @(negedge i_clk);
        slave_respond(1'b0, 1'b0);
        i_if_cyc  = 1'b1;
        i_if_addr = 32'h600;
        @(negedge i_clk);
        slave_respond(1'b0, 1'b1);
        i_if_cyc = 1'b0;
        #1;
        n_checks++;
        if ({o_if_err, o_if_ack, o_d_err} !== 3'b100) begin
            n_fail++;
            $display("FAIL err_fetch: got if_err%b if_ack%b d_err%b required 1 0 0", o_if_err, o_if_ack, o_d_err);
        end
        @(negedge i_clk);
        slave_respond(1'b0, 1'b0);
        #1;
        n_checks++;
        if (o_dbg_state !== ARB_IDLE) begin
            n_fail++;
            $display("FAIL err_idle: got state %0d required 0", o_dbg_state);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [31:0] e;
        @(negedge i_clk);
        d_read(32'h700);
        @(negedge i_clk);
        #1;
        n_checks++;
        if ({o_dbg_state, o_wb_cyc} !== {ARB_GNT_D, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_mid_grant: got state %0d cyc%b required 2 1", o_dbg_state, o_wb_cyc);
        end
        #1;
        i_reset_n = 1'b0;
        i_wb_ack  = 1'b1;
        i_wb_dat  = 32'h1234_5678;
        #1;
        n_checks++;
        if (all_outs() !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %h required 0", all_outs());
        end
        @(negedge i_clk);
        idle_inputs();
        i_reset_n = 1'b1;
        @(negedge i_clk);
        #1;
        n_checks++;
        if ({o_dbg_state, o_wb_cyc, dut.starve_cnt, dut.if_abandon} !== {ARB_IDLE, 1'b0, 4'd0, 1'b0}
            || dut.u_watchdog.cnt != 0) begin
            n_fail++;
            $display("FAIL rst_mid_state: got state %0d cyc%b starve %0d abandon %b wd %0d required 0 0 0 0 0",
                     o_dbg_state, o_wb_cyc, dut.starve_cnt, dut.if_abandon, dut.u_watchdog.cnt);
        end
        d_read(32'h800);
        exp_q.push_back(mem_fn(32'h800));
        @(negedge i_clk);
        wait_bus(ok);
        slave_respond(1'b1, 1'b0);
        i_d_cyc = 1'b0;
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if ({ok, o_wb_adr, o_d_ack, o_d_rdata} !== {1'b1, 32'h800, 1'b1, e}) begin
            n_fail++;
            $display("FAIL rst_mid_recover: got granted%b adr %h ack%b data %h required 1 00000800 1 %h",
                     ok, o_wb_adr, o_d_ack, o_d_rdata, e);
        end
        @(negedge i_clk);
        slave_respond(1'b0, 1'b0);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_fetch();
        test_starvation();
        test_abandon();
        test_write();
        test_timeout();
        test_err_ack();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
